// File: rtl/exec_pkg.sv
// exec_pkg: definitions shared by the reservation stations and execution units.
//   - Bit positions of the fields inside a reservation-station entry.
//   - mul_op_t: RV32M multiply flavour carried with each entry.
//   - TAG_WIDTH: ROB/CDB tag width.
//   - extend33(): widens a 32-bit operand to 33 bits, signed or unsigned, so one
//     signed 33x33 multiplier covers every multiply flavour.
package exec_pkg;

  localparam int TAG_WIDTH = 6;

  localparam int RD_TAG_LSB   = 0;
  localparam int RD_TAG_MSB   = 5;
  localparam int RS2_TAG_LSB  = 6;
  localparam int RS2_TAG_MSB  = 11;
  localparam int RS2_VALID    = 12;
  localparam int RS2_DATA_LSB = 13;
  localparam int RS2_DATA_MSB = 44;
  localparam int RS1_TAG_LSB  = 45;
  localparam int RS1_TAG_MSB  = 50;
  localparam int RS1_VALID    = 51;
  localparam int RS1_DATA_LSB = 52;
  localparam int RS1_DATA_MSB = 83;
  localparam int MUL_OP_LSB   = 84;
  localparam int MUL_OP_MSB   = 85;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  function automatic logic [32:0] extend33(input logic [31:0] value, input logic is_signed);
    return {is_signed & value[31], value};
  endfunction

endpackage

// File: rtl/exec_pipe_stage.sv
// exec_pipe_stage: one valid/data register slice of a stallable pipeline.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               clears the valid bit at the next edge
//   in_valid/in_ready     upstream handshake (in_ready = empty or draining)
//   in_data               payload captured when in_valid & in_ready
//   out_valid/out_ready   downstream handshake
//   out_data              registered payload
// A stalled slice (valid and not out_ready) holds its contents unchanged.
module exec_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  assign in_ready  = ~valid_reg | out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (i_flush) begin
      valid_reg <= 1'b0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/exec_mul_issue_unit.sv
// exec_mul_issue_unit: 3-stage pipelined RV32M multiplier fed by the multiply
// reservation station and retiring results over the CDB.
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_flush              synchronous flush of every in-flight entry
//   i_issue_rdy          RS presents a ready entry on i_issue_data
//   i_issue_data         RS entry (field layout in exec_pkg)
//   o_issue_completed    entry accepted this cycle (combinational)
//   o_cdb_req            result valid, requesting the CDB
//   i_cdb_grant          CDB grant; transfer on req & grant
//   o_cdb_tag/o_cdb_data result tag/value, zero while not requesting
//   o_busy               any stage holds a valid entry
// S1 holds extended operands, S2 the 66-bit product, S3 the selected result.
module exec_mul_issue_unit #(
  parameter int DATA_WIDTH = 128,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_issue_rdy,
  input  logic [DATA_WIDTH-1:0] i_issue_data,
  output logic                  o_issue_completed,
  output logic                  o_cdb_req,
  input  logic                  i_cdb_grant,
  output logic [TAG_WIDTH-1:0]  o_cdb_tag,
  output logic [31:0]           o_cdb_data,
  output logic                  o_busy
);

  import exec_pkg::*;

  localparam int S1_W = 2 + TAG_WIDTH + 66;
  localparam int S2_W = 2 + TAG_WIDTH + 66;
  localparam int S3_W = TAG_WIDTH + 32;

  // Issue-side decode
  mul_op_t             issue_op;
  logic [TAG_WIDTH-1:0] issue_tag;
  logic                rs1_signed;
  logic                rs2_signed;
  logic [S1_W-1:0]     s1_in_data;

  assign issue_op   = mul_op_t'(i_issue_data[MUL_OP_MSB:MUL_OP_LSB]);
  assign issue_tag  = i_issue_data[RD_TAG_MSB:RD_TAG_LSB];
  // Only MULHU treats rs1 as unsigned; only MUL/MULH treat rs2 as signed.
  // For MUL the low word is identical either way, so signed is harmless.
  assign rs1_signed = (issue_op != MUL_OP_MULHU);
  assign rs2_signed = (issue_op == MUL_OP_MUL) || (issue_op == MUL_OP_MULH);
  assign s1_in_data = {issue_op, issue_tag,
                       extend33(i_issue_data[RS1_DATA_MSB:RS1_DATA_LSB], rs1_signed),
                       extend33(i_issue_data[RS2_DATA_MSB:RS2_DATA_LSB], rs2_signed)};

  // Stage handshake wires
  logic            s1_ready, s1_valid, s2_ready, s2_valid, s3_ready, s3_valid;
  logic            s3_advance;
  logic            cdb_req;
  logic [S1_W-1:0] s1_data;
  logic [S2_W-1:0] s2_in_data, s2_data;
  logic [S3_W-1:0] s3_in_data, s3_data;

  assign o_issue_completed = i_issue_rdy & s1_ready & ~i_flush;

  exec_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_flush),
    .in_valid  (i_issue_rdy & ~i_flush),
    .in_ready  (s1_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  // Multiply between S1 and S2: both operands already carry their sign
  // semantics in bit 32, so a single signed multiply serves all four ops.
  logic signed [32:0] s1_a, s1_b;
  logic signed [65:0] product;

  assign s1_a       = s1_data[65:33];
  assign s1_b       = s1_data[32:0];
  assign product    = s1_a * s1_b;
  assign s2_in_data = {s1_data[S1_W-1 -: 2], s1_data[66 +: TAG_WIDTH], product};

  exec_pipe_stage #(.WIDTH(S2_W)) u_s2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_flush),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in_data),
    .out_valid (s2_valid),
    .out_ready (s3_ready),
    .out_data  (s2_data)
  );

  // Result select between S2 and S3
  mul_op_t     s2_op;
  logic [31:0] s2_result;

  assign s2_op      = mul_op_t'(s2_data[S2_W-1 -: 2]);
  assign s2_result  = (s2_op == MUL_OP_MUL) ? s2_data[31:0] : s2_data[63:32];
  assign s3_in_data = {s2_data[66 +: TAG_WIDTH], s2_result};

  exec_pipe_stage #(.WIDTH(S3_W)) u_s3 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_flush),
    .in_valid  (s2_valid),
    .in_ready  (s3_ready),
    .in_data   (s3_in_data),
    .out_valid (s3_valid),
    .out_ready (s3_advance),
    .out_data  (s3_data)
  );

  // A grant during flush is ignored because req is forced low.
  assign cdb_req    = s3_valid & ~i_flush;
  assign s3_advance = cdb_req & i_cdb_grant;

  assign o_cdb_req  = cdb_req;
  assign o_cdb_tag  = cdb_req ? s3_data[32 +: TAG_WIDTH] : '0;
  assign o_cdb_data = cdb_req ? s3_data[31:0] : 32'd0;
  assign o_busy     = s1_valid | s2_valid | s3_valid;

  // Entry fields this unit never looks at; the two top product bits are
  // only sign extension of the 64-bit result.
  logic unused_bits;
  assign unused_bits = ^{i_issue_data[DATA_WIDTH-1:MUL_OP_MSB+1],
                         i_issue_data[RS1_VALID],
                         i_issue_data[RS1_TAG_MSB:RS1_TAG_LSB],
                         i_issue_data[RS2_VALID],
                         i_issue_data[RS2_TAG_MSB:RS2_TAG_LSB],
                         s2_data[65:64]};

endmodule

// File: tb/tb_exec_mul_issue_unit.sv
module tb_exec_mul_issue_unit;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_issue_rdy = 1'b0;
  logic [127:0] i_issue_data = '0;
  logic         o_issue_completed;
  logic         o_cdb_req;
  logic         i_cdb_grant = 1'b0;
  logic [5:0]   o_cdb_tag;
  logic [31:0]  o_cdb_data;
  logic         o_busy;

  int checks = 0;
  int errs   = 0;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  exec_mul_issue_unit #(.DATA_WIDTH(128), .TAG_WIDTH(6)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_flush           (i_flush),
    .i_issue_rdy       (i_issue_rdy),
    .i_issue_data      (i_issue_data),
    .o_issue_completed (o_issue_completed),
    .o_cdb_req         (o_cdb_req),
    .i_cdb_grant       (i_cdb_grant),
    .o_cdb_tag         (o_cdb_tag),
    .o_cdb_data        (o_cdb_data),
    .o_busy            (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: act=0x%0h req=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic per RV32M definitions.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin ps = sa * sb; return ps[31:0]; end
      2'b01: begin ps = sa * sb; return ps[63:32]; end
      2'b10: begin ps = sa * longint'(ub); return ps[63:32]; end
      default: begin pu = ua * ub; return pu[63:32]; end
    endcase
  endfunction

  function automatic logic [127:0] make_entry(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [5:0] tag);
    logic [127:0] e;
    e = {$urandom, $urandom, $urandom, $urandom};
    e[85:84] = op;
    e[83:52] = a;
    e[51]    = 1'b1;
    e[44:13] = b;
    e[12]    = 1'b1;
    e[5:0]   = tag;
    return e;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [127:0] random_entry();
    return make_entry(2'($urandom), pick_operand(), pick_operand(), 6'($urandom));
  endfunction

  // Stimulus observer: every accepted entry pushes its expected result;
  // a flush discards everything in flight.
  always @(negedge i_clk) begin
    if (i_flush) begin
      exp_q.delete();
    end else if (o_issue_completed) begin
      exp_t e;
      e.tag  = i_issue_data[5:0];
      e.data = ref_mul(i_issue_data[85:84], i_issue_data[83:52], i_issue_data[44:13]);
      exp_q.push_back(e);
    end
  end

  // Monitor: compares every CDB presentation with the oldest expected entry.
  always @(negedge i_clk) begin
    if (o_cdb_req) begin
      if (exp_q.size() == 0) begin
        check("cdb_spurious_req", 64'(o_cdb_req), 64'd0);
      end else begin
        check("cdb_tag", 64'(o_cdb_tag), 64'(exp_q[0].tag));
        check("cdb_data", 64'(o_cdb_data), 64'(exp_q[0].data));
        if (i_cdb_grant) void'(exp_q.pop_front());
      end
    end else begin
      check("cdb_idle_zero", {26'd0, o_cdb_tag, o_cdb_data}, 64'd0);
    end
  end

  task automatic drain();
    int n;
    i_issue_rdy = 1'b0;
    i_cdb_grant = 1'b1;
    n = 0;
    while (o_busy && n < 20) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("drain_idle", 64'(o_busy), 64'd0);
  endtask

  task automatic directed(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] tag, input logic [31:0] res);
    drain();
    @(posedge i_clk);
    #1;
    i_cdb_grant  = 1'b1;
    i_issue_rdy  = 1'b1;
    i_issue_data = make_entry(op, a, b, tag);
    @(negedge i_clk);
    check({nm, "_accept"}, 64'(o_issue_completed), 64'd1);
    @(posedge i_clk);
    #1;
    i_issue_rdy = 1'b0;
    @(negedge i_clk);
    check({nm, "_req_c1"}, 64'(o_cdb_req), 64'd0);
    @(negedge i_clk);
    check({nm, "_req_c2"}, 64'(o_cdb_req), 64'd0);
    @(negedge i_clk);
    check({nm, "_req_c3"}, 64'(o_cdb_req), 64'd1);
    check({nm, "_tag"}, 64'(o_cdb_tag), 64'(tag));
    check({nm, "_data"}, 64'(o_cdb_data), 64'(res));
    @(negedge i_clk);
    check({nm, "_idle_c4"}, 64'(o_busy), 64'd0);
  endtask

  task automatic backpressure();
    int acc;
    drain();
    @(posedge i_clk);
    #1;
    i_cdb_grant = 1'b0;
    acc = 0;
    for (int k = 1; k <= 4; k++) begin
      i_issue_rdy  = 1'b1;
      i_issue_data = make_entry(2'($urandom), $urandom, $urandom, 6'(k));
      @(negedge i_clk);
      if (o_issue_completed) acc++;
      @(posedge i_clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      if (o_issue_completed) acc++;
      @(posedge i_clk);
      #1;
    end
    check("bp_accept_count", 64'(acc), 64'd3);
    i_cdb_grant = 1'b1;
    @(negedge i_clk);
    check("bp_tag4_accept", 64'(o_issue_completed), 64'd1);
    check("bp_bcast_1", {63'd0, o_cdb_req, 58'd0, o_cdb_tag} , {63'd1, 58'd0, 6'd1});
    @(posedge i_clk);
    #1;
    i_issue_rdy = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge i_clk);
      check($sformatf("bp_bcast_%0d", k), {57'd0, o_cdb_req, o_cdb_tag}, {57'd0, 1'b1, 6'(k)});
    end
  endtask

  task automatic stall_stability();
    int n;
    logic [5:0]  t0;
    logic [31:0] d0;
    drain();
    @(posedge i_clk);
    #1;
    i_cdb_grant  = 1'b0;
    i_issue_rdy  = 1'b1;
    i_issue_data = random_entry();
    @(posedge i_clk);
    #1;
    i_issue_rdy = 1'b0;
    n = 0;
    while (!o_cdb_req && n < 10) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("stall_req_seen", 64'(o_cdb_req), 64'd1);
    t0 = o_cdb_tag;
    d0 = o_cdb_data;
    for (int k = 0; k < 5; k++) begin
      i_issue_rdy  = 1'($urandom);
      i_issue_data = random_entry();
      @(negedge i_clk);
      check("stall_hold", {25'd0, o_cdb_req, o_cdb_tag, o_cdb_data}, {25'd0, 1'b1, t0, d0});
      @(posedge i_clk);
      #1;
    end
    i_issue_rdy = 1'b0;
  endtask

  task automatic flush_test();
    drain();
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      i_issue_rdy  = 1'b1;
      i_issue_data = random_entry();
      @(posedge i_clk);
      #1;
    end
    i_flush      = 1'b1;
    i_issue_data = random_entry();
    @(negedge i_clk);
    check("flush_no_req", 64'(o_cdb_req), 64'd0);
    check("flush_no_accept", 64'(o_issue_completed), 64'd0);
    @(posedge i_clk);
    #1;
    i_flush     = 1'b0;
    i_issue_rdy = 1'b0;
    @(negedge i_clk);
    check("flush_busy_clear", 64'(o_busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("flush_no_late_req", 64'(o_cdb_req), 64'd0);
    end
  endtask

  task automatic async_reset_test();
    drain();
    @(posedge i_clk);
    #1;
    i_cdb_grant = 1'b0;
    i_issue_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_issue_data = random_entry();
      @(posedge i_clk);
      #1;
    end
    i_issue_rdy = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_outputs", {o_issue_completed, o_cdb_req, o_busy, o_cdb_tag, o_cdb_data}, 64'd0);
    exp_q.delete();
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check("reset_outputs", {o_issue_completed, o_cdb_req, o_busy, o_cdb_tag, o_cdb_data}, 64'd0);
    #20;
    i_rst_n = 1'b1;

    directed("mul_neg",  2'b00, 32'd7,        32'hFFFF_FFFD, 6'h05, 32'hFFFF_FFEB);
    directed("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h11, 32'hFFFF_FFFE);
    directed("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 6'h22, 32'h4000_0000);
    directed("mulhsu",   2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 6'h33, 32'hFFFF_FFFF);

    backpressure();
    stall_stability();
    flush_test();
    directed("post_flush", 2'b00, 32'd12345, 32'd678, 6'h2A, 32'd8369910);
    async_reset_test();
    directed("post_reset", 2'b01, 32'h1234_5678, 32'hFFFF_FFF0, 6'h3F,
             ref_mul(2'b01, 32'h1234_5678, 32'hFFFF_FFF0));

    // Randomized traffic with random grant gaps and occasional flushes.
    @(posedge i_clk);
    #1;
    for (int c = 0; c < 600; c++) begin
      i_issue_rdy  = ($urandom % 4) != 0;
      i_cdb_grant  = ($urandom % 3) != 0;
      i_flush      = ($urandom % 60) == 0;
      i_issue_data = random_entry();
      @(posedge i_clk);
      #1;
    end
    i_flush = 1'b0;
    drain();
    @(negedge i_clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

// File: doc/exec_mul_issue_unit.md
# exec_mul_issue_unit

Pipelined integer multiply execution unit sitting directly downstream of an `exec_rsv_station_shift` instance configured as the multiply reservation station. It accepts ready entries over the RS issue handshake and computes RV32M MUL/MULH/MULHSU/MULHU in a 3-stage stallable pipeline. It then arbitrates for the common data bus (CDB) with a request/grant handshake, back-pressuring the reservation station when the CDB is not granted.

## Interface
Parameters:
- `DATA_WIDTH`, 128: RS entry width.
- `TAG_WIDTH`, 6: ROB/CDB tag width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_flush`  in  1  synchronous pipeline flush (branch mispredict).
- `i_issue_rdy`  in  1  RS has a ready entry on `i_issue_data` (RS `issue_queue_rdy`).
- `i_issue_data`  in  DATA_WIDTH  RS entry (RS `data_out`).
- `o_issue_completed`  out  1  entry accepted this cycle (to RS `issue_completed`); combinational.
- `o_cdb_req`  out  1  result valid, requesting CDB.
- `i_cdb_grant`  in  1  CDB arbiter grant; transfer completes in any cycle with req & grant.
- `o_cdb_tag`  out  TAG_WIDTH  destination tag.
- `o_cdb_data`  out  32  result.
- `o_busy`  out  1  any stage valid.

## Operation
- Entry fields: rs1_data [83:52], rs1_valid [51], rs1_tag [50:45], rs2_data [44:13], rs2_valid [12], rs2_tag [11:6], rd_tag [5:0], mul_op [85:84]. mul_op encoding: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU. All other bits are ignored.
- Accept: `o_issue_completed = i_issue_rdy & s1_ready & ~i_flush`. The RS guarantees rs1_valid = rs2_valid = 1 whenever `i_issue_rdy` = 1; the unit does not check them.
- S1 (operand regs): latch rd_tag and op. Extend operands to 33 bits: rs1 is sign-extended for MUL/MULH/MULHSU, zero-extended for MULHU. rs2 is sign-extended for MUL/MULH, zero-extended for MULHSU/MULHU.
- S2 (product reg): 33x33 signed multiply into a 66-bit product; carry tag and op.
- S3 (result reg): select product[31:0] for MUL, otherwise product[63:32]; hold for the CDB.
- Stall rule, per stage: `sN_ready = ~sN_valid | sN_advance`. S3 advances on req & grant; S2 advances when S3 is ready; S1 advances when S2 is ready. A stalled stage holds its contents unchanged.
- Outputs: `o_cdb_req = s3_valid & ~i_flush`. `o_cdb_tag`/`o_cdb_data` equal the S3 contents when req = 1, and 0 otherwise. `o_busy = s1_valid | s2_valid | s3_valid`.
- Flush: all valid bits are cleared at the clock edge. During the flush cycle, `o_issue_completed` = 0 and `o_cdb_req` = 0 (a grant in that cycle is ignored). No CDB broadcast occurs for flushed entries.

## Timing
- Reset: all valid bits 0, data regs 0. `o_issue_completed` 0, `o_cdb_req` 0, `o_cdb_tag` 0, `o_cdb_data` 0, `o_busy` 0.
- Reset mid-operation discards all in-flight entries immediately (asynchronous).
- Latency: accept in cycle 0 -> `o_cdb_req` = 1 in cycle 3 with the correct tag and data. Grant in cycle 3 -> entry retired; S3 is free in cycle 4.
- Throughput: 1 op/cycle with continuous grant.
- Capacity: 3 entries. With grant held low, after 3 accepts `o_issue_completed` stays 0 until the first grant.
- Simultaneous grant and full pipeline: the whole pipe advances and a new entry is accepted in the same cycle (no bubble).
- Req stays asserted with stable tag and data until granted (no retraction except on flush or reset).

## Structure
- Shared package `exec_pkg`:
  - entry field bit positions (RS1_DATA_MSB/LSB, RS1_VALID, RS2_*, RD_TAG_*, MUL_OP_*);
  - `mul_op_t` enum;
  - TAG_WIDTH constant.
  The reservation stations and the other execution units reuse the same definitions.
- Sub-module `exec_pipe_stage`: parameterised-width valid/data register with flush, in_valid/in_ready/out_valid/out_ready handshake. Instantiated 3 times (S1, S2, S3); the multiply and result-select logic sits between instances.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD (-3), rd_tag 0x05, grant held high -> cycle 3: req = 1, tag 0x05, data 0xFFFFFFEB.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- Back-pressure: grant low, 4 back-to-back issues with tags 1-4 -> exactly 3 accepted. Then grant high -> tags broadcast 1, 2, 3, 4 in consecutive cycles, with tag 4 accepted in the first grant cycle.
- Flush with 3 entries in flight and grant high -> no req in the flush cycle or after; `o_busy` = 0 next cycle; a new issue afterwards returns a result 3 cycles later.
- Async reset asserted mid-stall -> all outputs 0 immediately. After release, the first issue completes with normal 3-cycle latency.
- Req stability: grant withheld for 5 cycles -> `o_cdb_tag`/`o_cdb_data` constant across all 5 cycles while the CDB operand ignores other traffic.
